// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8N1 UART transmitter among NUM_REQ byte requesters.
// Define UART_TX_ARB_TAG_EN to precede every data frame with a tag frame {4'hA, grant_id}.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int ACTIVE_TIMEOUT = 8
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic [ID_W-1:0]      o_Grant_Id,
  output logic                 o_Err
);

  localparam int               CNT_W     = $clog2(ACTIVE_TIMEOUT + 1);
  localparam int               EXT_N     = 2 ** (ID_W + 1);
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ACTIVE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
`ifdef UART_TX_ARB_TAG_EN
    S_TAG_ISSUE,
    S_TAG_WAIT,
`endif
    S_ISSUE,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_DRAIN
  } state_t;

`ifdef UART_TX_ARB_TAG_EN
  localparam logic [1:0] PH_ACT   = 2'd0;
  localparam logic [1:0] PH_DONE  = 2'd1;
  localparam logic [1:0] PH_DRAIN = 2'd2;
  logic [1:0] phase_q, phase_d;
`endif

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [EXT_N-1:0] dv_ext;
  logic [ID_W:0]    scan_idx;
  logic             req_found;
  logic [ID_W-1:0]  req_sel;
  logic [7:0]       req_byte;
  logic             timed_out;

  // Zero-padded so the wrapped scan index can address it directly.
  assign dv_ext    = {{(EXT_N - NUM_REQ){1'b0}}, i_Req_DV};
  // cnt_q holds the number of cycles elapsed since the start pulse.
  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (ID_W + 1)'(i);
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      if (!req_found && dv_ext[scan_idx]) begin
        req_found = 1'b1;
        req_sel   = scan_idx[ID_W-1:0];
      end
    end
    req_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++)
      if (req_sel == ID_W'(k)) req_byte = i_Req_Byte[8*k +: 8];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    err_d     = err_q;
`ifdef UART_TX_ARB_TAG_EN
    phase_d   = phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          grant_d = req_sel;
          data_d  = req_byte;
          ack_d   = NUM_REQ'(1) << req_sel;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
        tx_dv_d = 1'b1;
`ifdef UART_TX_ARB_TAG_EN
        tx_byte_d = 8'hA0 | 8'(grant_q);
        state_d   = S_TAG_ISSUE;
`else
        tx_byte_d = data_q;
        state_d   = S_ISSUE;
`endif
      end
`ifdef UART_TX_ARB_TAG_EN
      S_TAG_ISSUE: begin
        phase_d = PH_ACT;
        cnt_d   = CNT_W'(1);
        state_d = S_TAG_WAIT;
      end
      // Tag frame walks the same active/done/drain sequence as the data frame.
      S_TAG_WAIT: begin
        case (phase_q)
          PH_ACT: begin
            if (i_Tx_Active) phase_d = PH_DONE;
            else if (timed_out) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else cnt_d = cnt_q + CNT_W'(1);
          end
          PH_DONE: if (i_Tx_Done) phase_d = PH_DRAIN;
          default: begin
            if (!i_Tx_Done && !i_Tx_Active) begin
              tx_dv_d   = 1'b1;
              tx_byte_d = data_q;
              state_d   = S_ISSUE;
            end
          end
        endcase
      end
`endif
      S_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        if (i_Tx_Active) state_d = S_WAIT_DONE;
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WAIT_DONE: if (i_Tx_Done) state_d = S_DRAIN;
      S_DRAIN:     if (!i_Tx_Done && !i_Tx_Active) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
      phase_q   <= PH_ACT;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifdef UART_TX_ARB_TAG_EN
      phase_q   <= phase_d;
`endif
    end
  end

  assign o_Req_Ack  = ack_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Busy     = busy_q;
  assign o_Grant_Id = grant_q;
  assign o_Err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model (4 clocks/bit, Done held 2 cycles) plus a
// round-robin reference model that predicts the ack/frame event stream for each batch.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_dv = '0;
  logic [NUM_REQ-1:0]   acked = '0;
  logic [NUM_REQ-1:0]   dut_req_dv;
  logic [8*NUM_REQ-1:0] req_byte = '0;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_dv;
  logic [7:0]           tx_byte;
  logic                 tx_active = 1'b0;
  logic                 tx_done = 1'b0;
  logic                 busy;
  logic [ID_W-1:0]      gid;
  logic                 err;

  int         vectors = 0;
  int         miscompares = 0;
  int         ev_log[$];
  int         exp_ev[$];
  bit         auto_drop = 1'b1;
  bit         tx_silent = 1'b0;
  int         tx_cnt = 0;
  int         model_ptr = 0;
  logic [7:0] byte_v[NUM_REQ];

  assign dut_req_dv = req_dv & ~acked;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ACTIVE_TIMEOUT(8)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Req_DV(dut_req_dv), .i_Req_Byte(req_byte),
    .o_Req_Ack(ack), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active),
    .i_Tx_Done(tx_done), .o_Busy(busy), .o_Grant_Id(gid), .o_Err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Event encoding: ack of k -> 4096+k ; start pulse -> grant_id*256 + byte.
  always @(negedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!req_dv[k]) acked[k] = 1'b0;
      else if (rst_n && ack[k] && auto_drop) acked[k] = 1'b1;
    end
    if (rst_n) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (ack[k]) ev_log.push_back(4096 + k);
      if (tx_dv) begin
        ev_log.push_back(int'(gid) * 256 + int'(tx_byte));
        chk("dv_while_tx_busy", {30'b0, tx_done, tx_active}, 32'd0);
      end
    end
    if (tx_cnt == 0) begin
      if (tx_dv && !tx_silent) begin
        tx_cnt    = 1;
        tx_active = 1'b1;
      end
    end else begin
      tx_cnt++;
      if (tx_cnt == 41) begin
        tx_active = 1'b0;
        tx_done   = 1'b1;
      end else if (tx_cnt == 43) begin
        tx_done = 1'b0;
        tx_cnt  = 0;
      end
    end
  end

  function automatic void model_batch(input logic [NUM_REQ-1:0] mask, input int n_grants, input bit keep);
    logic [NUM_REQ-1:0] pend;
    int g;
    int c;
    pend = mask;
    for (int n = 0; n < n_grants; n++) begin
      g = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        c = (model_ptr + i) % NUM_REQ;
        if (g < 0 && pend[c]) g = c;
      end
      if (g < 0) break;
      exp_ev.push_back(4096 + g);
`ifdef UART_TX_ARB_TAG_EN
      exp_ev.push_back(g * 256 + (8'hA0 | g));
`endif
      exp_ev.push_back(g * 256 + int'(byte_v[g]));
      if (!keep) pend[g] = 1'b0;
      model_ptr = (g + 1) % NUM_REQ;
    end
  endfunction

  task automatic load_bytes();
    for (int k = 0; k < NUM_REQ; k++) req_byte[8*k +: 8] = byte_v[k];
  endtask

  task automatic wait_events(input int n, input string tag);
    int budget;
    budget = 8000;
    while (ev_log.size() < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (ev_log.size() < n) chk({tag, "_event_wait"}, ev_log.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 500;
    while (busy && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_tx"}, {30'b0, tx_active, tx_done}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic compare_events(input string tag);
    chk({tag, "_count"}, ev_log.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < ev_log.size(); i++)
      chk(tag, ev_log[i], exp_ev[i]);
  endtask

  task automatic run_batch(input logic [NUM_REQ-1:0] mask, input int n_grants, input bit keep,
                           input string tag);
    ev_log.delete();
    exp_ev.delete();
    model_batch(mask, n_grants, keep);
    load_bytes();
    auto_drop = !keep;
    req_dv    = mask;
    wait_events(exp_ev.size(), tag);
    req_dv = '0;
    wait_idle(tag);
    compare_events(tag);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ack"},   32'(ack),     32'd0);
    chk({pfx, "_txdv"},  32'(tx_dv),   32'd0);
    chk({pfx, "_txbyte"}, 32'(tx_byte), 32'd0);
    chk({pfx, "_busy"},  32'(busy),    32'd0);
    chk({pfx, "_gid"},   32'(gid),     32'd0);
    chk({pfx, "_err"},   32'(err),     32'd0);
  endtask

  task automatic apply_reset();
    req_dv = '0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n     = 1'b1;
    model_ptr = 0;
    @(negedge clk); #1;
  endtask

  initial begin
    int n;
    for (int k = 0; k < NUM_REQ; k++) byte_v[k] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Single request from requester 1
    ev_log.delete();
    exp_ev.delete();
    byte_v[1] = 8'h55;
    load_bytes();
    model_batch(4'b0010, NUM_REQ, 1'b0);
    auto_drop = 1'b1;
    req_dv = 4'b0010;
    @(negedge clk); #1;
    chk("single_ack", 32'(ack), 32'h2);
    chk("single_gid", 32'(gid), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("single_txdv", 32'(tx_dv), 32'd1);
`ifdef UART_TX_ARB_TAG_EN
    chk("single_txbyte", 32'(tx_byte), 32'hA1);
`else
    chk("single_txbyte", 32'(tx_byte), 32'h55);
`endif
    wait_events(exp_ev.size(), "single");
    req_dv = '0;
    wait_idle("single");
    compare_events("single");

    // Fairness with all requesters continuously valid
    apply_reset();
    for (int k = 0; k < NUM_REQ; k++) byte_v[k] = 8'h10 + 8'(k);
    run_batch(4'b1111, 5, 1'b1, "fair");

    // Pointer wrap: after requester 3, requester 0 outranks requester 2
    byte_v[3] = 8'($urandom);
    run_batch(4'b1000, NUM_REQ, 1'b0, "wrap_a");
    byte_v[0] = 8'($urandom);
    byte_v[2] = 8'($urandom);
    run_batch(4'b0101, NUM_REQ, 1'b0, "wrap_b");

    // Timeout: transmitter never goes active
    tx_silent = 1'b1;
    byte_v[1] = 8'h3C;
    load_bytes();
    auto_drop = 1'b1;
    req_dv = 4'b0010;
    n = 0;
    while (!tx_dv && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("tmo_dv_seen", 32'(tx_dv), 32'd1);
    repeat (7) @(negedge clk);
    #1;
    chk("tmo_err_early", 32'(err), 32'd0);
    @(negedge clk); #1;
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    req_dv    = '0;
    tx_silent = 1'b0;
    model_ptr = 2;
    repeat (2) @(negedge clk);
    #1;
    byte_v[2] = 8'hC3;
    run_batch(4'b0100, NUM_REQ, 1'b0, "after_tmo");
    chk("err_sticky", 32'(err), 32'd1);

    // Randomized request masks and bytes
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NUM_REQ; k++) byte_v[k] = 8'($urandom);
      run_batch(4'($urandom_range(1, 15)), NUM_REQ, 1'b0, "rand");
    end

    // Reset in the middle of a frame
    byte_v[2] = 8'h9A;
    load_bytes();
    auto_drop = 1'b1;
    req_dv = 4'b0100;
    n = 0;
    while (tx_cnt < 10 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("midrst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    req_dv = '0;
    n = 0;
    while (tx_cnt != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    rst_n     = 1'b1;
    model_ptr = 0;
    @(negedge clk); #1;
    byte_v[0] = 8'h01;
    byte_v[3] = 8'hF3;
    run_batch(4'b1001, NUM_REQ, 1'b0, "post_rst");

    // Requester 2 sends 0x7E (tag frame precedes it when tagging is built in)
    byte_v[2] = 8'h7E;
    run_batch(4'b0100, NUM_REQ, 1'b0, "tag_req2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
